// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: owns the fetch PC and runs a
// single-outstanding req/ready/rvalid handshake, presenting a NOP bubble when idle.
module if_fetch_unit #(
  parameter int                     PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
  parameter logic [31:0]            NOP_INST = 32'h00000013
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_work_ena,
  input  logic                i_stall,
  input  logic                i_redirect_valid,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  output logic                o_imem_req,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic                i_imem_ready,
  input  logic                i_imem_rvalid,
  input  logic [31:0]         i_imem_rdata,
  output logic [PC_WIDTH-1:0] o_if_pc,
  output logic [31:0]         o_if_inst,
  output logic                o_if_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                r_kill;
  logic                w_kill_nxt;
  logic [31:0]         r_buf;
  logic [31:0]         w_buf_nxt;
  logic [PC_WIDTH-1:0] w_redir_pc;
  logic                w_unused_lsbs;

  assign w_redir_pc    = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign w_unused_lsbs = ^i_redirect_pc[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_buf_nxt   = r_buf;
    o_imem_req  = 1'b0;
    o_if_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end else if (i_work_ena) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Gating with work_ena withdraws the request so no orphan response can follow.
        o_imem_req = i_work_ena;
        if (i_redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        if (o_imem_req && i_imem_ready) begin
          w_state_nxt = ST_WAIT;
          w_kill_nxt  = i_redirect_valid;
        end else if (!i_work_ena) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        if (i_imem_rvalid) begin
          if (r_kill || i_redirect_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_buf_nxt   = i_imem_rdata;
            w_state_nxt = ST_HOLD;
          end
        end else if (i_redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        o_if_valid = i_work_ena;
        if (i_redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REQ;
        end else if (i_work_ena && !i_stall) begin
          w_pc_nxt    = r_pc + PC_WIDTH'(4);
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_imem_addr = r_pc;
  assign o_if_inst   = o_if_valid ? r_buf : NOP_INST;
  assign o_if_pc     = o_if_valid ? r_pc : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus a few hand sequences
// (zero-wait streaming, long stall, PC wrap, reset mid-transaction).
module tb_if_fetch_unit;

  localparam logic [31:0] N = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        work_ena;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        auto_en;
  logic        h_rvalid;
  logic [31:0] h_rdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_work_ena       (work_ena),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ready     (imem_ready),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_if_pc          (if_pc),
    .o_if_inst        (if_inst),
    .o_if_valid       (if_valid)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h00500093;
  endfunction

  // Zero-wait memory: accepts whenever ready, answers the following cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
    end else begin
      m_rvalid <= imem_req && imem_ready;
      m_rdata  <= inst_of(imem_addr);
    end
  end

  assign imem_rvalid = auto_en ? m_rvalid : h_rvalid;
  assign imem_rdata  = auto_en ? m_rdata  : h_rdata;

  typedef struct {
    logic        rst, we, st, rv;
    logic [31:0] rpc;
    logic        rdy, rval;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic we, input logic st, input logic rv,
                              input logic [31:0] rpc, input logic rdy, input logic rval,
                              input logic [31:0] rdata, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rst = r; v.we = we; v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rval = rval;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; work_ena = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; h_rvalid = 1'b0; h_rdata = 32'h0; auto_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, compare the pre-edge outputs, then clock.
  task automatic apply_vec(input vec_t v, input string tag);
    rst = v.rst; work_ena = v.we; stall = v.st; redirect_valid = v.rv; redirect_pc = v.rpc;
    imem_ready = v.rdy; h_rvalid = v.rval; h_rdata = v.rdata;
    #1;
    chk({tag, ".req"},   32'(imem_req), 32'(v.e_req));
    chk({tag, ".addr"},  imem_addr,     v.e_addr);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v.e_valid));
    chk({tag, ".pc"},    if_pc,         v.e_pc);
    chk({tag, ".inst"},  if_inst,       v.e_inst);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] exp_pc;
    int          nvalid;
    bit          found;

    //         rst we st rv rpc           rdy rv rdata          req addr          vld pc            inst
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h0,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h00500093, 0, 32'h0,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   1, 32'h0,   32'h00500093));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h4,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h4,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h4,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h00A00113, 0, 32'h4,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h4,   1, 32'h4,   32'h00A00113));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h4,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h4,   1, 32'h4,   32'h00A00113));
    tbl.push_back(mk(0, 1, 0, 1, 32'h103, 0, 0, 32'h0,        1, 32'h8,   0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h11111111, 0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 1, 32'h200, 0, 0, 32'h0,        0, 32'h100, 1, 32'h100, 32'h11111111));
    tbl.push_back(mk(0, 1, 0, 1, 32'h300, 1, 0, 32'h0,        1, 32'h200, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0, 32'h300, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h300, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 1, 32'h103, 0, 0, 32'h0,        0, 32'h300, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 1, 32'h500, 0, 1, 32'h22222222, 0, 32'h100, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h500, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h500, 0, 32'h0,   N));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 32'h33333333, 0, 32'h500, 0, 32'h0,   N));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h500, 0, 32'h0,   N));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h500, 1, 32'h500, 32'h33333333));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h504, 0, 32'h0,   N));

    do_reset();
    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // PC wrap: redirect (with stray low bits) to the last word, consume, expect addr 0.
    do_reset();
    apply_vec(mk(0, 1, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, N), "wrap0");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'hFFFFFFFC, 0, 32'h0, N), "wrap1");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, N), "wrap2");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 0, 1, 32'h44444444, 0, 32'hFFFFFFFC, 0, 32'h0, N), "wrap3");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h44444444), "wrap4");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, N), "wrap5");

    // Reset while a response is outstanding; the late rvalid must be ignored.
    do_reset();
    apply_vec(mk(0, 1, 0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, N), "rst0");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h40, 0, 32'h0, N), "rst1");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h40, 0, 32'h0, N), "rst2");
    apply_vec(mk(1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h40, 0, 32'h0, N), "rst3");
    apply_vec(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h55555555, 0, 32'h0, 0, 32'h0, N), "rst4");
    apply_vec(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, N), "rst5");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, N), "rst6");
    apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0, N), "rst7");

    // Zero-wait streaming: one instruction every three cycles, sequential PCs.
    do_reset();
    auto_en = 1'b1; work_ena = 1'b1; imem_ready = 1'b1;
    exp_pc = 32'h0;
    nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (if_valid) begin
        chk($sformatf("stream_pc%0d", nvalid), if_pc, exp_pc);
        chk($sformatf("stream_inst%0d", nvalid), if_inst, inst_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        nvalid++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_count", 32'(nvalid), 32'd9);

    // Long stall while holding pc=8, then release.
    do_reset();
    auto_en = 1'b1; work_ena = 1'b1; imem_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      #1;
      if (if_valid && if_pc == 32'h8) begin
        found = 1'b1;
        stall = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("stall_reach_pc8", 32'(found), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d.valid", c), 32'(if_valid), 32'd1);
      chk($sformatf("stall%0d.pc", c), if_pc, 32'h8);
      chk($sformatf("stall%0d.inst", c), if_inst, inst_of(32'h8));
      chk($sformatf("stall%0d.req", c), 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("unstall.req", 32'(imem_req), 32'd1);
    chk("unstall.addr", imem_addr, 32'hC);
    chk("unstall.valid", 32'(if_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch producer that drives the if_pc/if_inst inputs of the IF/ID pipeline register.
- Owns the architectural fetch PC and runs a single-outstanding req/ready/rvalid handshake to instruction memory.
- Honours the same stall and work_ena controls as the IF/ID register. Accepts branch/jump redirects from EX.
- Presents the NOP encoding (addi x0,x0,0) with PC 0 whenever no valid instruction is available, so IF/ID latches a bubble.

Parameters:
- PC_WIDTH, `PC_WIDTH (32), width of all PC/address signals.
- RESET_PC, 0, fetch PC loaded on reset.
- NOP_INST, 32'h00000013, instruction presented when if_valid=0.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- work_ena  input  1  core run enable; low blocks new fetches and forces bubble output.
- stall  input  1  IF/ID hold from hazard unit; the held instruction is not consumed.
- redirect_valid  input  1  taken branch/jump/flush from EX; highest priority.
- redirect_pc  input  PC_WIDTH  redirect target; bits [1:0] forced to 0 internally.
- imem_req  output  1  fetch request valid.
- imem_addr  output  PC_WIDTH  fetch address (word aligned).
- imem_ready  input  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid; earliest the cycle after acceptance.
- imem_rdata  input  32  instruction word.
- if_pc  output  PC_WIDTH  PC of presented instruction; 0 when if_valid=0.
- if_inst  output  32  presented instruction; NOP_INST when if_valid=0.
- if_valid  output  1  if_inst/if_pc hold a real fetched instruction.

Behaviour:
- Reset (rst=1 at posedge): pc_reg=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=NOP_INST, if_pc=0. Reset mid-transaction abandons it; a late rvalid is ignored because state is IDLE.
- States are IDLE, REQ, WAIT and HOLD.
- IDLE: imem_req=0. work_ena=1 moves to REQ. A redirect loads pc_reg and stays in IDLE.
- REQ:
  - imem_req=1, imem_addr=pc_reg.
  - imem_ready=1 moves to WAIT.
  - redirect with ready=0: pc_reg<=redirect_pc and stay in REQ. The address may change while unaccepted.
  - redirect with ready=1: old address accepted; go to WAIT with kill<=1 and pc_reg<=redirect_pc.
- WAIT:
  - imem_req=0.
  - On rvalid with kill=1: drop the data, clear kill, go to REQ.
  - On rvalid with kill=0: buf<=imem_rdata, go to HOLD.
  - redirect in WAIT: pc_reg<=redirect_pc, kill<=1. If rvalid arrives the same cycle, drop that data and go to REQ.
- HOLD:
  - if_valid=work_ena, if_inst=buf, if_pc=pc_reg.
  - Priority order is redirect, then work_ena=0, then stall.
  - redirect: discard buf, pc_reg<=redirect_pc, go to REQ.
  - work_ena=0: stay in HOLD, output bubble.
  - stall=1: stay in HOLD, outputs stable.
  - Otherwise the instruction is consumed at this edge: pc_reg<=pc_reg+4 (wraps mod 2^PC_WIDTH), go to REQ if work_ena=1, else IDLE.
- work_ena=0 in REQ: the unaccepted request is withdrawn and the state returns to IDLE. In WAIT, the outstanding response still completes into HOLD.
- if_* outputs are combinational from state/buf/pc_reg. With zero-wait memory (ready=1, rvalid next cycle), the steady-state rate is 1 instruction per 3 cycles.
- Redirect and consume in the same cycle: redirect wins, so the held instruction is not consumed.
- At most one request is outstanding. imem_req is never asserted in WAIT or HOLD.

Test Plan:
- Reset release, work_ena=1, ready=1, rvalid one cycle after accept, rdata=32'h00500093 → imem_req at cycle 2 with addr 0. Cycle 4 shows if_valid=1, if_pc=0, if_inst=32'h00500093. Next request is addr 4.
- stall held high 5 cycles in HOLD at pc=8 → if_pc=8 and if_inst stable, imem_req=0. Drop stall → next request addr 12.
- redirect_valid with redirect_pc=0x103 in WAIT; rvalid two cycles later with 0xDEADBEEF → data dropped, if_valid stays 0. Next request addr 0x100.
- redirect in REQ with imem_ready=0 → following-cycle imem_addr equals the redirect target. Redirect with ready=1 → kill path exercised, stale data never presented.
- pc_reg=0xFFFFFFFC consumed → next imem_addr=0. work_ena low in HOLD → if_inst=NOP_INST, if_pc=0, no new request.
- rst asserted in WAIT, then rvalid arrives → no HOLD entry, outputs at reset values. Fetch restarts at RESET_PC.
